arbitro_registro: RTL and testbench

Round-robin write controller that shares the 12-bit `Registro` storage register between several requesters. Each requester raises a request with its data word. The block grants one requester at a time, drives the register's `L` and `EN` for exactly one cycle, and returns a one-cycle acknowledge once `QR` holds the new value. It sits between the requesting logic and `Registro`, which it owns exclusively; `Registro`'s `CLR` is wired to the same `CLR` as this block.

---
 rtl/arbitro_pkg.sv | 20 ++
 rtl/rr_select.sv | 37 +++
 rtl/arbitro_registro.sv | 116 +++++++++++
 tb/tb_arbitro_registro.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared state encoding, default width and round-robin pointer helper
package arbitro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 12;

  // Pointer advances past the winner, wrapping from n-1 back to 0.
  function automatic logic [2:0] rr_next_ptr(input logic [2:0] idx, input logic [3:0] n);
    if ({1'b0, idx} == n - 4'd1) begin
      return 3'd0;
    end
    return idx + 3'd1;
  endfunction

endpackage

// File: rtl/rr_select.sv
// rtl/rr_select.sv - combinational round-robin picker: lowest request at or above ptr, else lowest overall
module rr_select #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PW-1:0]    i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [PW-1:0]    o_idx
);

  logic w_hit;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_hit   = 1'b0;
    // Descending scans so the last assignment is the lowest qualifying index.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (i_req[i] && (i >= int'(i_ptr))) begin
        o_idx = PW'(i);
        w_hit = 1'b1;
      end
    end
    if (!w_hit) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (i_req[i]) begin
          o_idx = PW'(i);
        end
      end
    end
    if (i_req != '0) begin
      o_grant[o_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/arbitro_registro.sv
// rtl/arbitro_registro.sv - round-robin write controller owning the Registro storage register
// Optional readback comparator and ERR output enabled by ARB_READBACK_CHECK_EN.
module arbitro_registro
  import arbitro_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                     CLK,
  input  logic                     CLR,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ*WIDTH-1:0]   DATA,
  input  logic [WIDTH-1:0]         QR,
  output logic [WIDTH-1:0]         L,
  output logic                     EN,
  output logic [N_REQ-1:0]         GNT,
  output logic [N_REQ-1:0]         ACK,
  output logic [$clog2(N_REQ)-1:0] OWNER,
  output logic                     BUSY
`ifdef ARB_READBACK_CHECK_EN
  ,
  output logic                     ERR
`endif
);

  localparam int PW = $clog2(N_REQ);

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [WIDTH-1:0] r_dreg;
  logic             r_en;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_ack;
  logic             r_busy;

  logic [N_REQ-1:0] w_win_onehot;
  logic [PW-1:0]    w_win_idx;
  logic [PW-1:0]    w_next_ptr;
  logic [WIDTH-1:0] w_win_data;

  rr_select #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_rr_select (
    .i_req   (REQ),
    .i_ptr   (r_ptr),
    .o_grant (w_win_onehot),
    .o_idx   (w_win_idx)
  );

  assign w_next_ptr = PW'(rr_next_ptr(3'(w_win_idx), 4'(N_REQ)));
  assign w_win_data = DATA[int'(w_win_idx) * WIDTH +: WIDTH];

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_dreg  <= '0;
      r_en    <= 1'b0;
      r_gnt   <= '0;
      r_ack   <= '0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (REQ != '0) begin
            r_state <= ST_LOAD;
            r_dreg  <= w_win_data;
            r_ptr   <= w_next_ptr;
            r_owner <= w_win_idx;
            r_en    <= 1'b1;
            r_gnt   <= w_win_onehot;
            r_busy  <= 1'b1;
          end
        end
        ST_LOAD: begin
          // The grant vector becomes the acknowledge so a withdrawn REQ cannot cancel it.
          r_state <= ST_DONE;
          r_en    <= 1'b0;
          r_gnt   <= '0;
          r_ack   <= r_gnt;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_ack   <= '0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_en    <= 1'b0;
          r_gnt   <= '0;
          r_ack   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign L     = r_dreg;
  assign EN    = r_en;
  assign GNT   = r_gnt;
  assign ACK   = r_ack;
  assign OWNER = r_owner;
  assign BUSY  = r_busy;

`ifdef ARB_READBACK_CHECK_EN
  // QR only reflects the write during DONE, so the compare is qualified by state.
  assign ERR = (r_state == ST_DONE) && (QR != r_dreg);
`else
  logic w_unused_qr;
  assign w_unused_qr = ^QR;
`endif

endmodule

// File: tb/tb_arbitro_registro.sv
// tb/tb_arbitro_registro.sv - scoreboard bench for arbitro_registro with a behavioural Registro
module tb_arbitro_registro;

  localparam int NR = 4;
  localparam int W  = 12;

  logic            clk;
  logic            clr;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] data;
  logic [W-1:0]    qr;
  logic [W-1:0]    l_out;
  logic            en;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   ack;
  logic [1:0]      owner;
  logic            busy;
`ifdef ARB_READBACK_CHECK_EN
  logic            err;
`endif

  logic [W-1:0] reg_q;
  logic         qr_force;

  int checks;
  int failures;
  int cyc;
  int ack_count;
  int last_ack_cyc;
  logic en_prev;

  typedef struct {
    int         idx;
    logic [W-1:0] data;
    logic [W-1:0] qr;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  arbitro_registro #(
    .N_REQ (NR),
    .WIDTH (W)
  ) dut (
    .CLK   (clk),
    .CLR   (clr),
    .REQ   (req),
    .DATA  (data),
    .QR    (qr),
    .L     (l_out),
    .EN    (en),
    .GNT   (gnt),
    .ACK   (ack),
    .OWNER (owner),
    .BUSY  (busy)
`ifdef ARB_READBACK_CHECK_EN
    ,
    .ERR   (err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge clr) begin
    if (clr) reg_q <= '0;
    else if (en) reg_q <= l_out;
  end
  assign qr = qr_force ? '0 : reg_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, expv);
    end
  endtask

  task automatic push(input int idx, input logic [W-1:0] d);
    exp_t x;
    x.idx = idx; x.data = d; x.qr = d; x.err = 1'b0;
    sb.push_back(x);
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      if (en) begin
        check_val("en_width", 32'(en_prev), 0);
        if (sb.size() > 0) begin
          check_val("gnt", 32'(gnt), 32'(1) << sb[0].idx);
          check_val("l_data", 32'(l_out), 32'(sb[0].data));
        end
      end
      if (ack != '0) begin
        ack_count++;
        if (sb.size() == 0) begin
          check_val("ack_unexpected", 32'(ack), 0);
        end else begin
          e = sb.pop_front();
          check_val("ack", 32'(ack), 32'(1) << e.idx);
          check_val("owner", 32'(owner), 32'(e.idx));
          check_val("qr", 32'(qr), 32'(e.qr));
          check_val("busy_done", 32'(busy), 1);
`ifdef ARB_READBACK_CHECK_EN
          check_val("err", 32'(err), 32'(e.err));
`endif
        end
      end
      en_prev = en;
    end
  end

  task automatic run_txns(input int n, input bit rearm, input bit spacing);
    int prev;
    bit got;
    logic [NR-1:0] acked;
    prev = -1;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int w = 0; w < 20 && !got; w++) begin
        @(negedge clk);
        if (ack != '0) got = 1'b1;
      end
      if (!got) begin
        check_val("ack_timeout", 32'(got), 1);
        req = '0;
        return;
      end
      if (spacing && prev >= 0) check_val("ack_spacing", 32'(cyc - prev), 3);
      prev = cyc;
      last_ack_cyc = cyc;
      acked = ack;
      @(posedge clk); #1;
      if (k == n - 1) begin
        req = '0;
      end else begin
        req = req & ~acked;
        if (rearm) begin
          @(posedge clk); #1;
          for (int i = 0; i < NR; i++) begin
            if (acked[i]) data[i*W +: W] = ~data[i*W +: W];
          end
          req = req | acked;
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_l"}, 32'(l_out), 0);
    check_val({tag, "_en"}, 32'(en), 0);
    check_val({tag, "_gnt"}, 32'(gnt), 0);
    check_val({tag, "_ack"}, 32'(ack), 0);
    check_val({tag, "_busy"}, 32'(busy), 0);
    check_val({tag, "_owner"}, 32'(owner), 0);
    check_val({tag, "_qr"}, 32'(qr), 0);
  endtask

  initial begin
    int t0;
    int acks_before;
    bit got;
    checks = 0; failures = 0; cyc = 0; ack_count = 0; last_ack_cyc = 0;
    en_prev = 1'b0; qr_force = 1'b0;
    clr = 1'b1; req = '0; data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    clr = 1'b0;

    // single request
    push(0, 12'hA5C);
    data[0 +: W] = 12'hA5C;
    req = 4'b0001;
    t0 = cyc;
    run_txns(1, 1'b0, 1'b0);
    check_val("latency", 32'(last_ack_cyc - t0), 2);

    // contention from ptr=0: order 0,1,2,3,0
    do_reset();
    data = {12'h444, 12'h333, 12'h222, 12'h111};
    push(0, 12'h111); push(1, 12'h222); push(2, 12'h333); push(3, 12'h444);
    push(0, 12'hEEE);
    req = 4'b1111;
    run_txns(5, 1'b1, 1'b1);

    // pointer wrap: serve 2 first so ptr=3, then 0011
    do_reset();
    push(2, 12'h2A2);
    data[2*W +: W] = 12'h2A2;
    req = 4'b0100;
    run_txns(1, 1'b0, 1'b0);
    push(0, 12'h0B0); push(1, 12'h1B1);
    data[0 +: W] = 12'h0B0; data[W +: W] = 12'h1B1;
    req = 4'b0011;
    run_txns(2, 1'b0, 1'b0);

    // request withdrawn and data changed during LOAD
    push(2, 12'hABC);
    data[2*W +: W] = 12'hABC;
    req = 4'b0100;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (en) got = 1'b1;
    end
    check_val("withdraw_en_seen", 32'(got), 1);
    req = '0;
    data[2*W +: W] = 12'hDEF;
    run_txns(1, 1'b0, 1'b0);

`ifdef ARB_READBACK_CHECK_EN
    begin
      exp_t x;
      x.idx = 1; x.data = 12'hFFF; x.qr = 12'h000; x.err = 1'b1;
      sb.push_back(x);
    end
    qr_force = 1'b1;
    data[W +: W] = 12'hFFF;
    req = 4'b0010;
    run_txns(1, 1'b0, 1'b0);
    qr_force = 1'b0;
`endif

    // reset asserted mid-LOAD drops the write
    data[3*W +: W] = 12'h777;
    req = 4'b1000;
    got = 1'b0;
    for (int w = 0; w < 10 && !got; w++) begin
      @(negedge clk);
      if (en) got = 1'b1;
    end
    check_val("midload_en_seen", 32'(got), 1);
    clr = 1'b1;
    #1;
    check_idle_outputs("midload");
    acks_before = ack_count;
    @(posedge clk); #1;
    req = '0;
    clr = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check_val("no_ack_after_rst", 32'(ack_count), 32'(acks_before));
    check_val("qr_after_rst", 32'(qr), 0);
    check_val("sb_empty", 32'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
